// File: rtl/md_io_pkg.sv
// Shared types for the I/O configuration sequencer.
// Holds the packed configuration word and the sequencer state encoding.
package md_io_pkg;

  typedef struct packed {
    logic [1:0] multitap;
    logic       sms;
    logic [2:0] mouse_opt;
    logic       gun_opt;
  } md_io_cfg_t;

  typedef enum logic [2:0] {
    BOOT,
    IDLE,
    WAIT,
    APPLY,
    DEVRST
  } md_io_state_t;

endpackage

// File: rtl/md_th_activity.sv
// TH activity detector: registers the four TH data/direction bits.
// It flags any cycle-to-cycle change as a one-cycle activity event.
module md_th_activity (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] th,
  output logic       activity
);

  logic [3:0] th_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      th_prev <= '0;
    end else begin
      th_prev <= th;
    end
  end

  assign activity = |(th ^ th_prev);

endmodule

// File: rtl/md_io_cfg_seq.sv
// I/O configuration sequencer: it applies a requested pad configuration only after the TH lines go quiet, then pulses io_reset.
// Optional macro MD_IO_CFG_TIMEOUT_EN forces an apply after TIMEOUT_CYCLES in WAIT.
module md_io_cfg_seq #(
  parameter int QUIET_CYCLES   = 4096,
  parameter int RST_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_multitap,
  input  logic       req_sms,
  input  logic [2:0] req_mouse_opt,
  input  logic       req_gun_opt,
  input  logic [6:0] port1_in,
  input  logic [6:0] port2_in,
  input  logic [6:0] port1_dir,
  input  logic [6:0] port2_dir,
  output logic [1:0] multitap,
  output logic       sms,
  output logic [2:0] mouse_opt,
  output logic       gun_opt,
  output logic       io_reset,
  output logic       busy
);

  import md_io_pkg::*;

  localparam int QW = (QUIET_CYCLES > 1) ? $clog2(QUIET_CYCLES) : 1;
  localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [QW-1:0] QUIET_LAST = QW'(QUIET_CYCLES - 1);
  localparam logic [RW-1:0] RST_LAST   = RW'(RST_CYCLES - 1);

  md_io_state_t  state;
  md_io_cfg_t    req_cfg;
  md_io_cfg_t    pending;
  md_io_cfg_t    applied;
  logic [QW-1:0] quiet_cnt;
  logic [RW-1:0] rst_cnt;
  logic          th_activity;
  logic          unused_bits;

  assign req_cfg = {req_multitap, req_sms, req_mouse_opt, req_gun_opt};

  assign multitap  = applied.multitap;
  assign sms       = applied.sms;
  assign mouse_opt = applied.mouse_opt;
  assign gun_opt   = applied.gun_opt;

  md_th_activity u_th_activity (
    .clk      (clk),
    .reset    (reset),
    .th       ({port1_in[6], port2_in[6], port1_dir[6], port2_dir[6]}),
    .activity (th_activity)
  );

`ifdef MD_IO_CFG_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] tout_cnt;
  logic          tout_hit;

  assign tout_hit = (tout_cnt == TOUT_LAST);

  // Restarts whenever WAIT is (re)entered or the request moves, so the deadline tracks the latest request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tout_cnt <= '0;
    end else if (state != WAIT || req_cfg != pending) begin
      tout_cnt <= '0;
    end else if (!tout_hit) begin
      tout_cnt <= tout_cnt + 1'b1;
    end
  end

  assign unused_bits = ^{port1_in[5:0], port2_in[5:0], port1_dir[5:0], port2_dir[5:0]};
`else
  assign unused_bits = ^{port1_in[5:0], port2_in[5:0], port1_dir[5:0], port2_dir[5:0],
                         TIMEOUT_CYCLES};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= BOOT;
      applied   <= '0;
      pending   <= '0;
      quiet_cnt <= '0;
      rst_cnt   <= '0;
      io_reset  <= 1'b1;
      busy      <= 1'b1;
    end else begin
      case (state)
        BOOT: begin
          pending  <= req_cfg;
          io_reset <= 1'b0;
          state    <= APPLY;
        end
        IDLE: begin
          if (req_cfg != applied) begin
            pending   <= req_cfg;
            quiet_cnt <= '0;
            busy      <= 1'b1;
            state     <= WAIT;
          end
        end
        // A revert wins over everything; a new request restarts the quiet window like TH activity does.
        WAIT: begin
          if (req_cfg == applied) begin
            quiet_cnt <= '0;
            busy      <= 1'b0;
            state     <= IDLE;
          end else if (req_cfg != pending) begin
            pending   <= req_cfg;
            quiet_cnt <= '0;
`ifdef MD_IO_CFG_TIMEOUT_EN
          end else if (tout_hit) begin
            state     <= APPLY;
`endif
          end else if (th_activity) begin
            quiet_cnt <= '0;
          end else if (quiet_cnt == QUIET_LAST) begin
            state     <= APPLY;
          end else begin
            quiet_cnt <= quiet_cnt + 1'b1;
          end
        end
        APPLY: begin
          applied  <= pending;
          rst_cnt  <= '0;
          io_reset <= 1'b1;
          state    <= DEVRST;
        end
        DEVRST: begin
          if (rst_cnt == RST_LAST) begin
            io_reset <= 1'b0;
            busy     <= 1'b0;
            state    <= IDLE;
          end else begin
            rst_cnt  <= rst_cnt + 1'b1;
          end
        end
        default: begin
          io_reset <= 1'b1;
          busy     <= 1'b1;
          state    <= BOOT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_md_io_cfg_seq.sv
// Self-checking bench for md_io_cfg_seq with QUIET=8, RST=4, TIMEOUT=64.
// Expected timing comes from a quiet-run/timeout model over the bench's own stimulus history.
module tb_md_io_cfg_seq;

  localparam int QUIET = 8;
  localparam int RSTC  = 4;
  localparam int TOUT  = 64;
  localparam int MAXT  = 128;
`ifdef MD_IO_CFG_TIMEOUT_EN
  localparam bit TOUT_EN = 1'b1;
`else
  localparam bit TOUT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] req_multitap;
  logic       req_sms;
  logic [2:0] req_mouse_opt;
  logic       req_gun_opt;
  logic [6:0] port1_in, port2_in, port1_dir, port2_dir;
  logic [1:0] multitap;
  logic       sms;
  logic [2:0] mouse_opt;
  logic       gun_opt;
  logic       io_reset;
  logic       busy;
  logic [6:0] out_cfg;

  int checks = 0;
  int errors = 0;
  logic [6:0] cur_cfg;

  logic [6:0] obs_cfg  [MAXT+1];
  logic       obs_rst  [MAXT+1];
  logic       obs_busy [MAXT+1];
  bit         act      [MAXT+1];

  assign out_cfg = {multitap, sms, mouse_opt, gun_opt};

  md_io_cfg_seq #(
    .QUIET_CYCLES   (QUIET),
    .RST_CYCLES     (RSTC),
    .TIMEOUT_CYCLES (TOUT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_multitap  (req_multitap),
    .req_sms       (req_sms),
    .req_mouse_opt (req_mouse_opt),
    .req_gun_opt   (req_gun_opt),
    .port1_in      (port1_in),
    .port2_in      (port2_in),
    .port1_dir     (port1_dir),
    .port2_dir     (port2_dir),
    .multitap      (multitap),
    .sms           (sms),
    .mouse_opt     (mouse_opt),
    .gun_opt       (gun_opt),
    .io_reset      (io_reset),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic set_req(input logic [6:0] cfg);
    {req_multitap, req_sms, req_mouse_opt, req_gun_opt} = cfg;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Non-TH port bits must never count as activity.
  task automatic noise();
    port1_in[5:0]  = 6'($urandom);
    port2_in[5:0]  = 6'($urandom);
    port1_dir[5:0] = 6'($urandom);
    port2_dir[5:0] = 6'($urandom);
  endtask

  task automatic toggle_th();
    case ($urandom_range(0, 3))
      0:       port1_in[6]  = ~port1_in[6];
      1:       port2_in[6]  = ~port2_in[6];
      2:       port1_dir[6] = ~port1_dir[6];
      default: port2_dir[6] = ~port2_dir[6];
    endcase
  endtask

  function automatic logic [6:0] rand_cfg_except(input logic [6:0] a, input logic [6:0] b);
    logic [6:0] c;
    c = 7'($urandom);
    while (c == a || c == b) c = 7'($urandom);
    return c;
  endfunction

  // Tick 1 is the first edge that sees first_cfg; act[t] records a TH change presented to edge t.
  task automatic run_window(input int n, input logic [6:0] first_cfg, input int period,
                            input int toggle_until, input int chg_at, input logic [6:0] chg_cfg);
    for (int t = 1; t <= n; t++) begin
      act[t] = 1'b0;
      if (t == 1) set_req(first_cfg);
      if (t == chg_at) set_req(chg_cfg);
      if (period > 0 && (t % period) == 0 && t <= toggle_until) begin
        toggle_th();
        act[t] = 1'b1;
      end
      noise();
      tick();
      obs_cfg[t]  = out_cfg;
      obs_rst[t]  = io_reset;
      obs_busy[t] = busy;
    end
  endtask

  // Reference: apply after QUIET consecutive quiet WAIT cycles (or TOUT WAIT cycles with the timeout),
  // outputs move one cycle later, then RSTC cycles of io_reset; a revert to the old config just goes idle.
  function automatic void predict(input int n, input logic [6:0] old_cfg, input logic [6:0] first_cfg,
                                  input int chg_at, input logic [6:0] chg_cfg,
                                  output int apply_t, output int idle_t, output logic [6:0] target);
    int run;
    int age;
    run = 0;
    age = 0;
    apply_t = 0;
    idle_t = n + 1;
    target = first_cfg;
    for (int t = 2; t <= n && apply_t == 0 && idle_t > n; t++) begin
      if (t == chg_at) begin
        target = chg_cfg;
        run = 0;
        age = 0;
        if (target == old_cfg) idle_t = t;
      end else begin
        age++;
        if (act[t]) run = 0;
        else run++;
        if (run == QUIET || (TOUT_EN && age == TOUT)) begin
          apply_t = t + 1;
          idle_t  = t + 1 + RSTC;
        end
      end
    end
  endfunction

  task automatic test_boot(input logic [6:0] cfg);
    logic [6:0] ec;
    logic       er, eb;
    reset = 1'b1;
    set_req(cfg);
    noise();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_cfg !== 7'b0) begin errors++; $display("[TB] FAIL reset_cfg: got %b expected %b", out_cfg, 7'b0); end
    checks++;
    if (io_reset !== 1'b1) begin errors++; $display("[TB] FAIL reset_io_reset: got %b expected 1", io_reset); end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 1", busy); end
    reset = 1'b0;
    for (int t = 1; t <= 8; t++) begin
      noise();
      tick();
      ec = (t >= 2) ? cfg : 7'b0;
      er = (t >= 2 && t <= 1 + RSTC);
      eb = (t <= 1 + RSTC);
      checks++;
      if (out_cfg !== ec) begin errors++; $display("[TB] FAIL boot_cfg t=%0d: got %b expected %b", t, out_cfg, ec); end
      checks++;
      if (io_reset !== er) begin errors++; $display("[TB] FAIL boot_io_reset t=%0d: got %b expected %b", t, io_reset, er); end
      checks++;
      if (busy !== eb) begin errors++; $display("[TB] FAIL boot_busy t=%0d: got %b expected %b", t, busy, eb); end
    end
    cur_cfg = cfg;
  endtask

  task automatic test_quiet_change();
    logic [6:0] nc, cc, tgt, ec;
    logic       er, eb;
    int         apply_t, idle_t, chg;
    for (int i = 0; i < 4; i++) begin
      nc  = (i == 0) ? 7'b000_0000 : (i == 1) ? 7'b010_0000 : rand_cfg_except(cur_cfg, cur_cfg);
      chg = (i == 3) ? int'($urandom_range(2, 6)) : 0;
      cc  = rand_cfg_except(cur_cfg, nc);
      run_window(24, nc, 0, 0, chg, cc);
      predict(24, cur_cfg, nc, chg, cc, apply_t, idle_t, tgt);
      for (int t = 1; t <= 24; t++) begin
        ec = (apply_t != 0 && t >= apply_t) ? tgt : cur_cfg;
        er = (apply_t != 0 && t >= apply_t && t < apply_t + RSTC);
        eb = (t < idle_t);
        checks++;
        if (obs_cfg[t] !== ec) begin errors++; $display("[TB] FAIL quiet_cfg i=%0d t=%0d: got %b expected %b", i, t, obs_cfg[t], ec); end
        checks++;
        if (obs_rst[t] !== er) begin errors++; $display("[TB] FAIL quiet_io_reset i=%0d t=%0d: got %b expected %b", i, t, obs_rst[t], er); end
        checks++;
        if (obs_busy[t] !== eb) begin errors++; $display("[TB] FAIL quiet_busy i=%0d t=%0d: got %b expected %b", i, t, obs_busy[t], eb); end
      end
      if (apply_t != 0) cur_cfg = tgt;
    end
  endtask

  task automatic test_activity();
    logic [6:0] nc, tgt, ec;
    logic       er, eb;
    int         apply_t, idle_t, period;
    for (int i = 0; i < 2; i++) begin
      period = (i == 0) ? 5 : int'($urandom_range(2, 7));
      nc = rand_cfg_except(cur_cfg, cur_cfg);
      run_window(60, nc, period, 40, 0, 7'b0);
      predict(60, cur_cfg, nc, 0, 7'b0, apply_t, idle_t, tgt);
      for (int t = 1; t <= 60; t++) begin
        ec = (apply_t != 0 && t >= apply_t) ? tgt : cur_cfg;
        er = (apply_t != 0 && t >= apply_t && t < apply_t + RSTC);
        eb = (t < idle_t);
        checks++;
        if (obs_cfg[t] !== ec) begin errors++; $display("[TB] FAIL activity_cfg p=%0d t=%0d: got %b expected %b", period, t, obs_cfg[t], ec); end
        checks++;
        if (obs_rst[t] !== er) begin errors++; $display("[TB] FAIL activity_io_reset p=%0d t=%0d: got %b expected %b", period, t, obs_rst[t], er); end
        checks++;
        if (obs_busy[t] !== eb) begin errors++; $display("[TB] FAIL activity_busy p=%0d t=%0d: got %b expected %b", period, t, obs_busy[t], eb); end
      end
      if (apply_t != 0) cur_cfg = tgt;
    end
  endtask

  task automatic test_revert();
    logic [6:0] nc, tgt, ec;
    logic [2:0] mflip;
    logic       er, eb;
    int         apply_t, idle_t, d;
    for (int i = 0; i < 2; i++) begin
      d = (i == 0) ? 3 : int'($urandom_range(1, 6));
      mflip = (i == 0) ? 3'b001 : 3'($urandom_range(1, 7));
      nc = cur_cfg ^ {3'b000, mflip, 1'b0};
      run_window(16, nc, 0, 0, 1 + d, cur_cfg);
      predict(16, cur_cfg, nc, 1 + d, cur_cfg, apply_t, idle_t, tgt);
      for (int t = 1; t <= 16; t++) begin
        ec = (apply_t != 0 && t >= apply_t) ? tgt : cur_cfg;
        er = (apply_t != 0 && t >= apply_t && t < apply_t + RSTC);
        eb = (t < idle_t);
        checks++;
        if (obs_cfg[t] !== ec) begin errors++; $display("[TB] FAIL revert_cfg d=%0d t=%0d: got %b expected %b", d, t, obs_cfg[t], ec); end
        checks++;
        if (obs_rst[t] !== er) begin errors++; $display("[TB] FAIL revert_io_reset d=%0d t=%0d: got %b expected %b", d, t, obs_rst[t], er); end
        checks++;
        if (obs_busy[t] !== eb) begin errors++; $display("[TB] FAIL revert_busy d=%0d t=%0d: got %b expected %b", d, t, obs_busy[t], eb); end
      end
    end
  endtask

  task automatic test_timeout();
    logic [6:0] nc, tgt, ec;
    logic       er, eb;
    int         apply_t, idle_t;
    nc = rand_cfg_except(cur_cfg, cur_cfg);
    run_window(100, nc, 2, 80, 0, 7'b0);
    predict(100, cur_cfg, nc, 0, 7'b0, apply_t, idle_t, tgt);
    for (int t = 1; t <= 100; t++) begin
      ec = (apply_t != 0 && t >= apply_t) ? tgt : cur_cfg;
      er = (apply_t != 0 && t >= apply_t && t < apply_t + RSTC);
      eb = (t < idle_t);
      checks++;
      if (obs_cfg[t] !== ec) begin errors++; $display("[TB] FAIL timeout_cfg t=%0d: got %b expected %b", t, obs_cfg[t], ec); end
      checks++;
      if (obs_rst[t] !== er) begin errors++; $display("[TB] FAIL timeout_io_reset t=%0d: got %b expected %b", t, obs_rst[t], er); end
      checks++;
      if (obs_busy[t] !== eb) begin errors++; $display("[TB] FAIL timeout_busy t=%0d: got %b expected %b", t, obs_busy[t], eb); end
    end
    if (apply_t != 0) cur_cfg = tgt;
  endtask

  // A request landing during the io_reset pulse waits for IDLE, then runs a full quiet window.
  task automatic test_back_to_back();
    logic [6:0] a, b, ec;
    logic       er, eb;
    int         a_t, b_t;
    a = rand_cfg_except(cur_cfg, cur_cfg);
    b = rand_cfg_except(cur_cfg, a);
    a_t = 2 + QUIET;
    b_t = a_t + RSTC + 1 + 1 + QUIET;
    for (int t = 1; t <= 30; t++) begin
      if (t == 1) set_req(a);
      if (t == a_t + 1) set_req(b);
      noise();
      tick();
      ec = (t < a_t) ? cur_cfg : (t < b_t) ? a : b;
      er = (t >= a_t && t < a_t + RSTC) || (t >= b_t && t < b_t + RSTC);
      eb = (t < a_t + RSTC) || (t > a_t + RSTC && t < b_t + RSTC);
      checks++;
      if (out_cfg !== ec) begin errors++; $display("[TB] FAIL b2b_cfg t=%0d: got %b expected %b", t, out_cfg, ec); end
      checks++;
      if (io_reset !== er) begin errors++; $display("[TB] FAIL b2b_io_reset t=%0d: got %b expected %b", t, io_reset, er); end
      checks++;
      if (busy !== eb) begin errors++; $display("[TB] FAIL b2b_busy t=%0d: got %b expected %b", t, busy, eb); end
    end
    cur_cfg = b;
  endtask

  task automatic test_mid_reset();
    logic [6:0] nc;
    nc = rand_cfg_except(cur_cfg, 7'b0);
    set_req(nc);
    for (int t = 1; t <= 3 + QUIET; t++) begin
      noise();
      tick();
    end
    checks++;
    if (out_cfg !== nc) begin errors++; $display("[TB] FAIL midrst_pre_cfg: got %b expected %b", out_cfg, nc); end
    checks++;
    if (io_reset !== 1'b1) begin errors++; $display("[TB] FAIL midrst_pre_io_reset: got %b expected 1", io_reset); end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (out_cfg !== 7'b0) begin errors++; $display("[TB] FAIL midrst_cfg: got %b expected %b", out_cfg, 7'b0); end
    checks++;
    if (io_reset !== 1'b1) begin errors++; $display("[TB] FAIL midrst_io_reset: got %b expected 1", io_reset); end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("[TB] FAIL midrst_busy: got %b expected 1", busy); end
    test_boot(rand_cfg_except(7'b0, 7'b0));
  endtask

  initial begin
    port1_in  = '0;
    port2_in  = '0;
    port1_dir = '0;
    port2_dir = '0;
    set_req(7'b0);
    cur_cfg = 7'b0;
    $display("[TB] boot");
    test_boot(7'b100_0000);
    $display("[TB] quiet change");
    test_quiet_change();
    $display("[TB] activity");
    test_activity();
    $display("[TB] revert");
    test_revert();
    $display("[TB] timeout (enabled=%0d)", TOUT_EN);
    test_timeout();
    $display("[TB] back to back");
    test_back_to_back();
    $display("[TB] mid-sequence reset");
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/md_io_cfg_seq.md
MD_IO_CFG_SEQ -- requirements
Module: md_io_cfg_seq

Interface
REQ-001 The module SHALL have parameter QUIET_CYCLES, default 4096: number of consecutive TH-idle cycles required before a configuration change is applied.
REQ-002 The module SHALL have parameter RST_CYCLES, default 16: length in cycles of the io_reset pulse after an apply.
REQ-003 The module SHALL have parameter TIMEOUT_CYCLES, default 1048576: cycles in WAIT after which an apply is forced (only with MD_IO_CFG_TIMEOUT_EN).
REQ-004 clk  input  1  system clock; all logic is in this single clock domain.
REQ-005 reset  input  1  reset, asynchronous and active-high.
REQ-006 req_multitap  input  2  requested multitap mode.
REQ-007 req_sms  input  1  requested SMS mode.
REQ-008 req_mouse_opt  input  3  requested mouse options.
REQ-009 req_gun_opt  input  1  requested light-gun enable.
REQ-010 port1_in, port2_in  input  7 each  CPU-driven port data; bit 6 is TH.
REQ-011 port1_dir, port2_dir  input  7 each  CPU port direction; bit 6 is the TH direction.
REQ-012 multitap  output  2  applied multitap mode.
REQ-013 sms  output  1  applied SMS mode.
REQ-014 mouse_opt  output  3  applied mouse options.
REQ-015 gun_opt  output  1  applied gun enable.
REQ-016 io_reset  output  1  active-high reset to the pad/multitap logic.
REQ-017 busy  output  1  high whenever the state is not IDLE.

Function
REQ-018 The requested configuration SHALL be the 7-bit vector {req_multitap, req_sms, req_mouse_opt, req_gun_opt}, and the applied configuration SHALL be the matching output vector.
REQ-019 The FSM SHALL have states BOOT, IDLE, WAIT, APPLY and DEVRST.
REQ-020 BOOT SHALL go to APPLY on the first clock after reset release, with no quiet wait.
REQ-021 In IDLE, if requested differs from applied, the block SHALL latch requested into pending, clear the quiet counter and enter WAIT on the next clock.
REQ-022 An activity event SHALL be any cycle-to-cycle change of port1_in[6], port2_in[6], port1_dir[6] or port2_dir[6], using registered previous values.
REQ-023 In WAIT, an activity event SHALL clear the quiet counter; otherwise the counter SHALL increment, saturating.
REQ-024 In WAIT, a change of requested SHALL reload pending and clear the quiet counter.
REQ-025 In WAIT, if requested equals applied, the block SHALL return to IDLE with no apply and no io_reset pulse.
REQ-026 In WAIT, when the quiet counter reaches QUIET_CYCLES-1 with no activity event that cycle, the block SHALL enter APPLY.
REQ-027 APPLY SHALL last exactly 1 cycle, load the applied outputs from pending on its exit edge and enter DEVRST.
REQ-028 DEVRST SHALL assert io_reset for exactly RST_CYCLES cycles and then enter IDLE.
REQ-029 Request changes during APPLY or DEVRST SHALL be ignored until IDLE, where the normal mismatch check applies on the next cycle.
REQ-030 The applied outputs SHALL change only at the APPLY exit edge and never glitch between applies.
REQ-031 The counters SHALL be sized by $clog2 of their parameter and SHALL NOT wrap.

Reset
REQ-032 While reset is high, state SHALL be BOOT, applied outputs 0, pending 0, counters 0, io_reset 1 and busy 1.
REQ-033 Assertion of reset mid-sequence SHALL abort immediately, discarding pending.

Configuration
REQ-034 With MD_IO_CFG_TIMEOUT_EN defined, a WAIT timeout counter SHALL clear on entering WAIT and on any requested change, and reaching TIMEOUT_CYCLES-1 SHALL force APPLY regardless of activity.
REQ-035 Without MD_IO_CFG_TIMEOUT_EN, WAIT SHALL persist indefinitely under continuous activity, and no timeout logic SHALL be present.

Structure
REQ-036 Package md_io_pkg SHALL hold typedef md_io_cfg_t (the packed 7-bit configuration struct) and the FSM state enum.
REQ-037 Sub-module md_th_activity SHALL register the four TH bits and output the one-cycle activity event.

Verification (QUIET_CYCLES=8, RST_CYCLES=4, TIMEOUT_CYCLES=64)
REQ-038 Boot: release reset with requested multitap=2 -> outputs updated after 1 APPLY cycle, io_reset high 4 cycles, then busy=0.
REQ-039 Quiet change: req_multitap 0->1 with TH static -> multitap=1 exactly 1+8+1 cycles after the request, then a 4-cycle io_reset.
REQ-040 Activity: toggle port1_in[6] every 5 cycles for 40 cycles -> no apply; 8 quiet cycles after the last toggle -> apply.
REQ-041 Revert: request mouse_opt 0->1, then back to 0 after 3 cycles in WAIT -> return to IDLE, io_reset never asserted.
REQ-042 Timeout: continuous TH toggling every 2 cycles -> with the macro, apply at WAIT cycle 64; without it, busy stays 1.
REQ-043 Mid-reset: assert reset during DEVRST -> outputs 0 and io_reset 1 immediately, then the BOOT sequence reruns after release.
